// File: rtl/axis_latency_sink.sv
// AXI-Stream traffic sink: random tready backpressure, per-packet latency stats, optional log2 histogram (AXIS_LATENCY_SINK_HIST_EN).
// Latency: statistics update one cycle after the tlast handshake; hist_count is combinational from hist_sel.
// Backpressure: tready low in IDLE/DONE, high in DRAIN, LFSR-gated against ready_load in RUN.
module axis_latency_sink #(
    parameter int TDATA_WIDTH = 64,
    parameter int TDEST_WIDTH = 2,
    parameter int TID_WIDTH   = 2,
    parameter int COUNT_WIDTH = 32,
    parameter int TDEST       = 0,
    parameter int NUM_ROUTERS = 4,
    parameter int SEED        = 1,
    parameter int DRAIN_IDLE  = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic [15:0]                        ready_load,
    input  logic [TDATA_WIDTH/2-1:0]           ticks,
    input  logic                               axis_in_tvalid,
    output logic                               axis_in_tready,
    input  logic [TDATA_WIDTH-1:0]             axis_in_tdata,
    input  logic                               axis_in_tlast,
    input  logic [TID_WIDTH-1:0]               axis_in_tid,
    input  logic [TDEST_WIDTH-1:0]             axis_in_tdest,
    output logic                               done,
    output logic                               error,
    output logic [COUNT_WIDTH-1:0]             pkt_count,
    output logic [COUNT_WIDTH-1:0]             beat_count,
    output logic [2*COUNT_WIDTH-1:0]           lat_sum,
    output logic [COUNT_WIDTH-1:0]             lat_min,
    output logic [COUNT_WIDTH-1:0]             lat_max,
    output logic [NUM_ROUTERS*COUNT_WIDTH-1:0] src_pkts,
    input  logic [3:0]                         hist_sel,
    output logic [COUNT_WIDTH-1:0]             hist_count
);

    localparam int HW = TDATA_WIDTH / 2;
    localparam int IW = (DRAIN_IDLE > 1) ? $clog2(DRAIN_IDLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [15:0]              lfsr_q, lfsr_d;
    logic [IW-1:0]            idle_q, idle_d;
    logic                     first_q, first_d;
    logic [HW-1:0]            stamp_q, stamp_d;
    logic                     upd_q, upd_d;
    logic [COUNT_WIDTH-1:0]   upd_lat_q, upd_lat_d;
    logic [TID_WIDTH-1:0]     upd_tid_q, upd_tid_d;
    logic                     error_q, error_d;
    logic [COUNT_WIDTH-1:0]   pkt_q, pkt_d;
    logic [COUNT_WIDTH-1:0]   beat_q, beat_d;
    logic [2*COUNT_WIDTH-1:0] sum_q, sum_d;
    logic [COUNT_WIDTH-1:0]   min_q, min_d;
    logic [COUNT_WIDTH-1:0]   max_q, max_d;
    logic [COUNT_WIDTH-1:0]   src_q [NUM_ROUTERS];
    logic [COUNT_WIDTH-1:0]   src_d [NUM_ROUTERS];

    logic                     tready_c;
    logic                     accept_c;
    logic [HW-1:0]            cur_stamp_c;
    logic [HW-1:0]            diff_c;
    logic                     unused_tdata;

    assign unused_tdata = ^axis_in_tdata[HW-1:0];

    // Fibonacci LFSR, taps 16,14,13,11; never reaches zero from a nonzero seed
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_comb begin
        tready_c = 1'b0;
        case (state_q)
            S_RUN:   tready_c = (ready_load == 16'hFFFF) || (lfsr_q < ready_load);
            S_DRAIN: tready_c = 1'b1;
            default: tready_c = 1'b0;
        endcase
    end

    assign accept_c = axis_in_tvalid && tready_c;

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        case (state_q)
            S_IDLE: if (enable) state_d = S_RUN;
            S_RUN: begin
                if (!enable) begin
                    state_d = S_DRAIN;
                    idle_d  = '0;
                end
            end
            S_DRAIN: begin
                if (axis_in_tvalid) begin
                    idle_d = '0;
                end else if (idle_q == IW'(DRAIN_IDLE - 1)) begin
                    state_d = S_DONE;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
            S_DONE: if (enable) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Single-beat packets take their stamp straight off the bus
    assign cur_stamp_c = first_q ? axis_in_tdata[TDATA_WIDTH-1:HW] : stamp_q;
    assign diff_c      = ticks - cur_stamp_c;

    always_comb begin
        first_d   = first_q;
        stamp_d   = stamp_q;
        upd_d     = 1'b0;
        upd_lat_d = upd_lat_q;
        upd_tid_d = upd_tid_q;
        beat_d    = beat_q;
        error_d   = error_q;
        if (accept_c) begin
            beat_d  = beat_q + COUNT_WIDTH'(1);
            stamp_d = cur_stamp_c;
            first_d = axis_in_tlast;
            if (axis_in_tdest != TDEST_WIDTH'(TDEST)) error_d = 1'b1;
            if (axis_in_tlast) begin
                upd_d     = 1'b1;
                upd_lat_d = COUNT_WIDTH'(diff_c);
                upd_tid_d = axis_in_tid;
            end
        end
        if (upd_q && (int'(upd_tid_q) >= NUM_ROUTERS)) error_d = 1'b1;
    end

    always_comb begin
        pkt_d = pkt_q;
        sum_d = sum_q;
        min_d = min_q;
        max_d = max_q;
        for (int i = 0; i < NUM_ROUTERS; i++) src_d[i] = src_q[i];
        if (upd_q) begin
            pkt_d = pkt_q + COUNT_WIDTH'(1);
            sum_d = sum_q + (2*COUNT_WIDTH)'(upd_lat_q);
            if (upd_lat_q < min_q) min_d = upd_lat_q;
            if (upd_lat_q > max_q) max_d = upd_lat_q;
            for (int i = 0; i < NUM_ROUTERS; i++) begin
                if (int'(upd_tid_q) == i) src_d[i] = src_q[i] + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            lfsr_q    <= 16'(SEED);
            idle_q    <= '0;
            first_q   <= 1'b1;
            stamp_q   <= '0;
            upd_q     <= 1'b0;
            upd_lat_q <= '0;
            upd_tid_q <= '0;
            error_q   <= 1'b0;
            pkt_q     <= '0;
            beat_q    <= '0;
            sum_q     <= '0;
            min_q     <= '1;
            max_q     <= '0;
            for (int i = 0; i < NUM_ROUTERS; i++) src_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            idle_q    <= idle_d;
            first_q   <= first_d;
            stamp_q   <= stamp_d;
            upd_q     <= upd_d;
            upd_lat_q <= upd_lat_d;
            upd_tid_q <= upd_tid_d;
            error_q   <= error_d;
            pkt_q     <= pkt_d;
            beat_q    <= beat_d;
            sum_q     <= sum_d;
            min_q     <= min_d;
            max_q     <= max_d;
            for (int i = 0; i < NUM_ROUTERS; i++) src_q[i] <= src_d[i];
        end
    end

`ifdef AXIS_LATENCY_SINK_HIST_EN
    logic [COUNT_WIDTH-1:0] hist_q [16];
    logic [COUNT_WIDTH-1:0] hist_d [16];
    logic [3:0]             hist_bin_c;

    // floor(log2) via highest set bit, saturating at bin 15; zero falls in bin 0
    always_comb begin
        hist_bin_c = '0;
        for (int i = 1; i < COUNT_WIDTH; i++) begin
            if (upd_lat_q[i]) hist_bin_c = (i > 15) ? 4'd15 : 4'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) hist_d[i] = hist_q[i];
        if (upd_q) hist_d[hist_bin_c] = hist_q[hist_bin_c] + COUNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) hist_q[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++) hist_q[i] <= hist_d[i];
        end
    end

    assign hist_count = hist_q[hist_sel];
`else
    logic unused_hist_sel;
    assign unused_hist_sel = ^hist_sel;
    assign hist_count      = '0;
`endif

    assign axis_in_tready = tready_c;
    assign done           = (state_q == S_DONE);
    assign error          = error_q;
    assign pkt_count      = pkt_q;
    assign beat_count     = beat_q;
    assign lat_sum        = sum_q;
    assign lat_min        = min_q;
    assign lat_max        = max_q;

    for (genvar g = 0; g < NUM_ROUTERS; g++) begin : g_src
        assign src_pkts[g*COUNT_WIDTH +: COUNT_WIDTH] = src_q[g];
    end

endmodule

// File: tb/tb_axis_latency_sink.sv
// Directed bench for axis_latency_sink with default parameters (64-bit tdata, 32-bit ticks).
module tb_axis_latency_sink;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [15:0]   ready_load;
    logic [31:0]   ticks;
    logic          axis_in_tvalid;
    logic          axis_in_tready;
    logic [63:0]   axis_in_tdata;
    logic          axis_in_tlast;
    logic [1:0]    axis_in_tid;
    logic [1:0]    axis_in_tdest;
    logic          done;
    logic          error;
    logic [31:0]   pkt_count;
    logic [31:0]   beat_count;
    logic [63:0]   lat_sum;
    logic [31:0]   lat_min;
    logic [31:0]   lat_max;
    logic [127:0]  src_pkts;
    logic [3:0]    hist_sel;
    logic [31:0]   hist_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axis_latency_sink dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ready_load(ready_load), .ticks(ticks),
        .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
        .axis_in_tdata(axis_in_tdata), .axis_in_tlast(axis_in_tlast),
        .axis_in_tid(axis_in_tid), .axis_in_tdest(axis_in_tdest),
        .done(done), .error(error), .pkt_count(pkt_count), .beat_count(beat_count),
        .lat_sum(lat_sum), .lat_min(lat_min), .lat_max(lat_max), .src_pkts(src_pkts),
        .hist_sel(hist_sel), .hist_count(hist_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        axis_in_tvalid = 1'b0;
        axis_in_tlast = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    // Presents one beat and holds it until the handshake edge has passed.
    task automatic send_beat(input logic [31:0] stamp, input logic last, input logic [1:0] tid,
                             input logic [1:0] tdest, input logic [31:0] tk);
        int waitn;
        waitn = 0;
        axis_in_tdata  = {stamp, 32'hDEAD_BEEF};
        axis_in_tlast  = last;
        axis_in_tid    = tid;
        axis_in_tdest  = tdest;
        ticks          = tk;
        axis_in_tvalid = 1'b1;
        while (!axis_in_tready && waitn < 200) begin
            tick;
            waitn++;
        end
        checks++;
        if (axis_in_tready !== 1'b1) begin
            $display("FAIL handshake_timeout: tready=%0b required 1", axis_in_tready);
            errors++;
        end
        tick;
        axis_in_tvalid = 1'b0;
        axis_in_tlast  = 1'b0;
    endtask

    task automatic test_reset;
        enable = 1'b0; ready_load = 16'hFFFF; ticks = '0; axis_in_tdata = '0;
        axis_in_tid = '0; axis_in_tdest = '0; hist_sel = '0;
        do_reset;
        checks++; if (axis_in_tready !== 1'b0) begin $display("FAIL reset_tready: got %0b required 0", axis_in_tready); errors++; end
        checks++; if (done !== 1'b0) begin $display("FAIL reset_done: got %0b required 0", done); errors++; end
        checks++; if (error !== 1'b0) begin $display("FAIL reset_error: got %0b required 0", error); errors++; end
        checks++; if (pkt_count !== 32'd0) begin $display("FAIL reset_pkt: got %0d required 0", pkt_count); errors++; end
        checks++; if (beat_count !== 32'd0) begin $display("FAIL reset_beat: got %0d required 0", beat_count); errors++; end
        checks++; if (lat_sum !== 64'd0) begin $display("FAIL reset_sum: got %0d required 0", lat_sum); errors++; end
        checks++; if (lat_min !== 32'hFFFF_FFFF) begin $display("FAIL reset_min: got %h required ffffffff", lat_min); errors++; end
        checks++; if (lat_max !== 32'd0) begin $display("FAIL reset_max: got %0d required 0", lat_max); errors++; end
        checks++; if (src_pkts !== 128'd0) begin $display("FAIL reset_src: got %h required 0", src_pkts); errors++; end
        checks++; if (hist_count !== 32'd0) begin $display("FAIL reset_hist: got %0d required 0", hist_count); errors++; end
    endtask

    task automatic test_single_beat;
        enable = 1'b1;
        tick;
        checks++; if (axis_in_tready !== 1'b1) begin $display("FAIL run_tready_full_load: got %0b required 1", axis_in_tready); errors++; end
        send_beat(32'd100, 1'b1, 2'd0, 2'd0, 32'd130);
        checks++; if (pkt_count !== 32'd0) begin $display("FAIL single_pkt_early: got %0d required 0", pkt_count); errors++; end
        tick;
        checks++; if (pkt_count !== 32'd1) begin $display("FAIL single_pkt: got %0d required 1", pkt_count); errors++; end
        checks++; if (lat_min !== 32'd30) begin $display("FAIL single_min: got %0d required 30", lat_min); errors++; end
        checks++; if (lat_max !== 32'd30) begin $display("FAIL single_max: got %0d required 30", lat_max); errors++; end
        checks++; if (lat_sum !== 64'd30) begin $display("FAIL single_sum: got %0d required 30", lat_sum); errors++; end
        checks++; if (beat_count !== 32'd1) begin $display("FAIL single_beat: got %0d required 1", beat_count); errors++; end
        checks++; if (src_pkts[31:0] !== 32'd1) begin $display("FAIL single_src0: got %0d required 1", src_pkts[31:0]); errors++; end
    endtask

    task automatic test_multi_beat;
        send_beat(32'd10, 1'b0, 2'd1, 2'd0, 32'd20);
        send_beat(32'd0,  1'b0, 2'd1, 2'd0, 32'd22);
        send_beat(32'd0,  1'b1, 2'd1, 2'd0, 32'd25);
        tick;
        checks++; if (pkt_count !== 32'd2) begin $display("FAIL multi_pkt: got %0d required 2", pkt_count); errors++; end
        checks++; if (lat_min !== 32'd15) begin $display("FAIL multi_min: got %0d required 15", lat_min); errors++; end
        checks++; if (lat_max !== 32'd30) begin $display("FAIL multi_max: got %0d required 30", lat_max); errors++; end
        checks++; if (lat_sum !== 64'd45) begin $display("FAIL multi_sum: got %0d required 45", lat_sum); errors++; end
        checks++; if (beat_count !== 32'd4) begin $display("FAIL multi_beat: got %0d required 4", beat_count); errors++; end
        checks++; if (src_pkts[63:32] !== 32'd1) begin $display("FAIL multi_src1: got %0d required 1", src_pkts[63:32]); errors++; end
    endtask

    task automatic test_wrap;
        send_beat(32'hFFFF_FFF0, 1'b1, 2'd2, 2'd0, 32'h10);
        tick;
        checks++; if (lat_max !== 32'h20) begin $display("FAIL wrap_max: got %h required 20", lat_max); errors++; end
        checks++; if (lat_sum !== 64'd77) begin $display("FAIL wrap_sum: got %0d required 77", lat_sum); errors++; end
        checks++; if (lat_min !== 32'd15) begin $display("FAIL wrap_min: got %0d required 15", lat_min); errors++; end
        checks++; if (src_pkts[95:64] !== 32'd1) begin $display("FAIL wrap_src2: got %0d required 1", src_pkts[95:64]); errors++; end
    endtask

    task automatic test_mid_reset;
        send_beat(32'd5, 1'b0, 2'd0, 2'd0, 32'd6);
        do_reset;
        tick;
        send_beat(32'd100, 1'b1, 2'd0, 2'd0, 32'd107);
        tick;
        checks++; if (pkt_count !== 32'd1) begin $display("FAIL midrst_pkt: got %0d required 1", pkt_count); errors++; end
        checks++; if (lat_sum !== 64'd7) begin $display("FAIL midrst_sum: got %0d required 7", lat_sum); errors++; end
        checks++; if (beat_count !== 32'd1) begin $display("FAIL midrst_beat: got %0d required 1", beat_count); errors++; end
    endtask

    task automatic test_histogram;
        do_reset;
        tick;
        send_beat(32'd50,   1'b1, 2'd0, 2'd0, 32'd51);
        send_beat(32'd200,  1'b1, 2'd1, 2'd0, 32'd203);
        send_beat(32'd1000, 1'b1, 2'd3, 2'd0, 32'd1040);
        tick;
        checks++; if (pkt_count !== 32'd3) begin $display("FAIL hist_pkt: got %0d required 3", pkt_count); errors++; end
        checks++; if (lat_sum !== 64'd44) begin $display("FAIL hist_sum: got %0d required 44", lat_sum); errors++; end
        checks++; if (lat_min !== 32'd1) begin $display("FAIL hist_min: got %0d required 1", lat_min); errors++; end
        checks++; if (lat_max !== 32'd40) begin $display("FAIL hist_max: got %0d required 40", lat_max); errors++; end
        checks++; if (src_pkts[127:96] !== 32'd1) begin $display("FAIL hist_src3: got %0d required 1", src_pkts[127:96]); errors++; end
`ifdef AXIS_LATENCY_SINK_HIST_EN
        hist_sel = 4'd0; #1;
        checks++; if (hist_count !== 32'd1) begin $display("FAIL hist_bin0: got %0d required 1", hist_count); errors++; end
        hist_sel = 4'd1; #1;
        checks++; if (hist_count !== 32'd1) begin $display("FAIL hist_bin1: got %0d required 1", hist_count); errors++; end
        hist_sel = 4'd5; #1;
        checks++; if (hist_count !== 32'd1) begin $display("FAIL hist_bin5: got %0d required 1", hist_count); errors++; end
        hist_sel = 4'd4; #1;
        checks++; if (hist_count !== 32'd0) begin $display("FAIL hist_bin4: got %0d required 0", hist_count); errors++; end
`else
        hist_sel = 4'd0; #1;
        checks++; if (hist_count !== 32'd0) begin $display("FAIL hist_off0: got %0d required 0", hist_count); errors++; end
        hist_sel = 4'd5; #1;
        checks++; if (hist_count !== 32'd0) begin $display("FAIL hist_off5: got %0d required 0", hist_count); errors++; end
`endif
    endtask

    task automatic test_duty;
        int hi;
        hi = 0;
        ready_load = 16'h8000;
        repeat (10000) begin
            tick;
            if (axis_in_tready) hi++;
        end
        checks++; if (hi < 4500 || hi > 5500) begin $display("FAIL duty_half: got %0d ready cycles required 4500..5500", hi); errors++; end
        hi = 0;
        ready_load = 16'h0000;
        repeat (1000) begin
            tick;
            if (axis_in_tready) hi++;
        end
        checks++; if (hi != 0) begin $display("FAIL duty_zero: got %0d ready cycles required 0", hi); errors++; end
        ready_load = 16'hFFFF;
    endtask

    task automatic test_error_drain;
        tick;
        checks++; if (error !== 1'b0) begin $display("FAIL err_pre: got %0b required 0", error); errors++; end
        send_beat(32'd0, 1'b1, 2'd0, 2'd1, 32'd9);
        tick;
        checks++; if (error !== 1'b1) begin $display("FAIL err_tdest: got %0b required 1", error); errors++; end
        checks++; if (pkt_count !== 32'd4) begin $display("FAIL err_pkt: got %0d required 4", pkt_count); errors++; end
        checks++; if (lat_sum !== 64'd53) begin $display("FAIL err_sum: got %0d required 53", lat_sum); errors++; end
        enable = 1'b0;
        tick;
        checks++; if (axis_in_tready !== 1'b1) begin $display("FAIL drain_tready: got %0b required 1", axis_in_tready); errors++; end
        repeat (63) tick;
        checks++; if (done !== 1'b0) begin $display("FAIL drain_done_early: got %0b required 0", done); errors++; end
        tick;
        checks++; if (done !== 1'b1) begin $display("FAIL drain_done: got %0b required 1", done); errors++; end
        checks++; if (axis_in_tready !== 1'b0) begin $display("FAIL done_tready: got %0b required 0", axis_in_tready); errors++; end
        checks++; if (error !== 1'b1) begin $display("FAIL err_sticky: got %0b required 1", error); errors++; end
        enable = 1'b1;
        tick;
        checks++; if (done !== 1'b0) begin $display("FAIL rerun_done: got %0b required 0", done); errors++; end
        checks++; if (pkt_count !== 32'd4) begin $display("FAIL rerun_keep_pkt: got %0d required 4", pkt_count); errors++; end
        checks++; if (axis_in_tready !== 1'b1) begin $display("FAIL rerun_tready: got %0b required 1", axis_in_tready); errors++; end
    endtask

    initial begin
        test_reset;
        test_single_beat;
        test_multi_beat;
        test_wrap;
        test_mid_reset;
        test_histogram;
        test_duty;
        test_error_drain;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
